// File: rtl/spi_p2s_stream_if.sv
// Stream/FIFO-side signal bundle for spi_p2s_stream.
// The slave modport is the serializer; the master modport is the FIFO/controller side.
interface spi_p2s_stream_if #(
  parameter int unsigned DATAWIDTH = 8
);
  logic                 p2s_enable;
  logic                 bit_tick;
  logic [DATAWIDTH-1:0] rdata;
  logic                 not_empty;
  logic                 ren;
  logic                 data_out;
  logic                 busy;
  logic                 frame_done;
  logic                 underrun;

  modport slave (
    input  p2s_enable, bit_tick, rdata, not_empty,
    output ren, data_out, busy, frame_done, underrun
  );

  modport master (
    output p2s_enable, bit_tick, rdata, not_empty,
    input  ren, data_out, busy, frame_done, underrun
  );
endinterface

// File: rtl/spi_p2s_stream.sv
// FIFO-fed parallel-to-serial streamer, one bit per bit_tick, back-to-back frames.
// Define SPI_P2S_PARITY_EN to append a parity bit slot after each data word.
module spi_p2s_stream #(
  parameter int unsigned DATAWIDTH  = 8,
  parameter int unsigned MSB_FIRST  = 1,
  parameter logic        IDLE_LEVEL = 1'b0,
  parameter int unsigned ODD_PARITY = 0
) (
  input  logic            clk,
  input  logic            rstn,
  spi_p2s_stream_if.slave bus
);

  localparam int unsigned CW = $clog2(DATAWIDTH + 2);
`ifdef SPI_P2S_PARITY_EN
  localparam int unsigned SLOTS = DATAWIDTH + 1;
`else
  localparam int unsigned SLOTS = DATAWIDTH;
`endif

  if (DATAWIDTH < 2 || DATAWIDTH > 32 || MSB_FIRST > 1 || ODD_PARITY > 1) begin : g_bad_params
  end

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t               state;
  logic [DATAWIDTH-1:0] shreg;
  logic [DATAWIDTH-1:0] next_shreg;
  logic [CW-1:0]        cnt;
  logic                 next_bit;
`ifdef SPI_P2S_PARITY_EN
  logic                 par_bit;
`endif

  always_comb begin
    if (MSB_FIRST != 0) begin
      next_bit   = shreg[DATAWIDTH-1];
      next_shreg = shreg << 1;
    end else begin
      next_bit   = shreg[0];
      next_shreg = shreg >> 1;
    end
`ifdef SPI_P2S_PARITY_EN
    if (cnt == CW'(1)) next_bit = par_bit;
`endif
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      shreg          <= '0;
      cnt            <= '0;
      bus.ren        <= 1'b0;
      bus.data_out   <= IDLE_LEVEL;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.underrun   <= 1'b0;
`ifdef SPI_P2S_PARITY_EN
      par_bit        <= 1'b0;
`endif
    end else begin
      bus.ren        <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.underrun   <= 1'b0;
      unique case (state)
        IDLE: begin
          bus.data_out <= IDLE_LEVEL;
          if (bus.p2s_enable && bus.not_empty) begin
            bus.ren  <= 1'b1;
            bus.busy <= 1'b1;
            state    <= LOAD;
          end else begin
            bus.busy <= 1'b0;
          end
        end
        // LOAD spans two cycles: the ren cycle, then the cycle rdata is valid.
        LOAD: begin
          if (!bus.ren) begin
            shreg <= bus.rdata;
            cnt   <= CW'(SLOTS);
`ifdef SPI_P2S_PARITY_EN
            par_bit <= (^bus.rdata) ^ ODD_PARITY[0];
`endif
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.bit_tick) begin
            bus.data_out <= next_bit;
            shreg        <= next_shreg;
            cnt          <= cnt - 1'b1;
            if (cnt == CW'(1)) begin
              bus.frame_done <= 1'b1;
              if (bus.p2s_enable && bus.not_empty) begin
                bus.ren <= 1'b1;
                state   <= LOAD;
              end else begin
                bus.underrun <= bus.p2s_enable;
                bus.busy     <= 1'b0;
                state        <= IDLE;
              end
            end
          end
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_p2s_stream.sv
// Directed bench: an MSB-first DUT and an LSB-first (ODD_PARITY=1) DUT share one FIFO model
// and stimulus; every bit slot, pulse and idle level is compared with hand-computed values.
module tb_spi_p2s_stream;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic en = 1'b0;
  logic tick = 1'b0;
  logic [7:0] rdata = '0;
  logic ne;

  logic [7:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int checks = 0;
  int errors = 0;
  int ren_cnt = 0;
  int fd_cnt = 0;
  int ur_cnt = 0;

  spi_p2s_stream_if #(.DATAWIDTH(8)) if_m ();
  spi_p2s_stream_if #(.DATAWIDTH(8)) if_l ();

  assign ne = (wr_ptr != rd_ptr);
  assign if_m.p2s_enable = en;
  assign if_m.bit_tick   = tick;
  assign if_m.rdata      = rdata;
  assign if_m.not_empty  = ne;
  assign if_l.p2s_enable = en;
  assign if_l.bit_tick   = tick;
  assign if_l.rdata      = rdata;
  assign if_l.not_empty  = ne;

  spi_p2s_stream #(.DATAWIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0), .ODD_PARITY(0))
    u_dut_m (.clk(clk), .rstn(rstn), .bus(if_m));
  spi_p2s_stream #(.DATAWIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0), .ODD_PARITY(1))
    u_dut_l (.clk(clk), .rstn(rstn), .bus(if_l));

  always #5 clk = ~clk;

  // FIFO model: registered read, data valid the cycle after ren
  always @(posedge clk) begin
    if (if_m.ren) begin
      rdata  <= mem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  always @(negedge clk) begin
    if (if_m.ren) ren_cnt++;
    if (if_m.frame_done) fd_cnt++;
    if (if_m.underrun) ur_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ren"},  32'(if_m.ren), 32'd0);
    check({tag, "_dout"}, 32'(if_m.data_out), 32'd0);
    check({tag, "_busy"}, 32'(if_m.busy), 32'd0);
    check({tag, "_fd"},   32'(if_m.frame_done), 32'd0);
    check({tag, "_ur"},   32'(if_m.underrun), 32'd0);
    check({tag, "_dout_l"}, 32'(if_l.data_out), 32'd0);
  endtask

  // em/el: expected slot sequences, first slot in bit 7
  task automatic run_frame(input string tag, input logic [7:0] w, input logic [7:0] em,
                           input logic [7:0] el, input int gap, input int drop_after,
                           input logic exp_ren, input logic exp_ur);
    int nslots = 8;
    logic xm, xl;
`ifdef SPI_P2S_PARITY_EN
    nslots = 9;
`endif
    for (int i = 0; i < nslots; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      if (i < 8) begin
        xm = em[7-i];
        xl = el[7-i];
      end else begin
        xm = ^w;
        xl = ~(^w);
      end
      check($sformatf("%s_m_bit%0d", tag, i), 32'(if_m.data_out), 32'(xm));
      check($sformatf("%s_l_bit%0d", tag, i), 32'(if_l.data_out), 32'(xl));
      check($sformatf("%s_fd%0d", tag, i), 32'(if_m.frame_done), 32'(i == nslots - 1));
      if (i == nslots - 1) begin
        check({tag, "_ur_end"},  32'(if_m.underrun), 32'(exp_ur));
        check({tag, "_ren_end"}, 32'(if_m.ren), 32'(exp_ren));
      end else begin
        check($sformatf("%s_busy%0d", tag, i), 32'(if_m.busy), 32'd1);
        if (i == drop_after - 1) en = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check({tag, "_idle_dout_m"}, 32'(if_m.data_out), 32'd0);
    check({tag, "_idle_dout_l"}, 32'(if_l.data_out), 32'd0);
    check({tag, "_idle_busy"},   32'(if_m.busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, f0, u0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_noren", 32'(ren_cnt), 32'd0);

    // A5, enable dropped after bit 3: graceful finish, no underrun
    r0 = ren_cnt; f0 = fd_cnt; u0 = ur_cnt;
    push(8'hA5); en = 1'b1;
    repeat (3) @(negedge clk);
    run_frame("a5", 8'hA5, 8'hA5, 8'hA5, 4, 3, 1'b0, 1'b0);
    check_idle("a5");
    check("a5_ren_cnt", 32'(ren_cnt - r0), 32'd1);
    check("a5_fd_cnt",  32'(fd_cnt - f0), 32'd1);
    check("a5_ur_cnt",  32'(ur_cnt - u0), 32'd0);

    // 01, enable held, FIFO runs dry: underrun with frame_done
    r0 = ren_cnt; u0 = ur_cnt;
    push(8'h01); en = 1'b1;
    repeat (3) @(negedge clk);
    run_frame("w01", 8'h01, 8'h01, 8'h80, 4, 0, 1'b0, 1'b1);
    check_idle("w01");
    en = 1'b0;
    check("w01_ren_cnt", 32'(ren_cnt - r0), 32'd1);
    check("w01_ur_cnt",  32'(ur_cnt - u0), 32'd1);

    // F0 then 0F back-to-back at minimum tick spacing
    r0 = ren_cnt; f0 = fd_cnt; u0 = ur_cnt;
    push(8'hF0); push(8'h0F); en = 1'b1;
    repeat (3) @(negedge clk);
    run_frame("b2b1", 8'hF0, 8'hF0, 8'h0F, 3, 0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    run_frame("b2b2", 8'h0F, 8'h0F, 8'hF0, 3, 0, 1'b0, 1'b1);
    check_idle("b2b");
    en = 1'b0;
    check("b2b_ren_cnt", 32'(ren_cnt - r0), 32'd2);
    check("b2b_fd_cnt",  32'(fd_cnt - f0), 32'd2);
    check("b2b_ur_cnt",  32'(ur_cnt - u0), 32'd1);

    // C3, enable dropped after bit 3
    r0 = ren_cnt; u0 = ur_cnt;
    push(8'hC3); en = 1'b1;
    repeat (3) @(negedge clk);
    run_frame("c3", 8'hC3, 8'hC3, 8'hC3, 4, 3, 1'b0, 1'b0);
    check_idle("c3");
    check("c3_ren_cnt", 32'(ren_cnt - r0), 32'd1);
    check("c3_ur_cnt",  32'(ur_cnt - u0), 32'd0);

    // 07: parity 1 for even sense, 0 for odd sense
    push(8'h07); en = 1'b1;
    repeat (3) @(negedge clk);
    run_frame("w07", 8'h07, 8'h07, 8'hE0, 5, 1, 1'b0, 1'b0);
    check_idle("w07");

    // reset after bit 4 of 5A drops the frame immediately
    r0 = ren_cnt;
    push(8'h5A); en = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      check($sformatf("rm_bit%0d", i), 32'(if_m.data_out), 32'((8'h5A >> (7 - i)) & 8'h01));
      repeat (2) @(negedge clk);
    end
    rstn = 1'b0;
    #1;
    check_reset_vals("rstmid");
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      check($sformatf("rpost_dout%0d", i), 32'(if_m.data_out), 32'd0);
      check($sformatf("rpost_busy%0d", i), 32'(if_m.busy), 32'd0);
      repeat (2) @(negedge clk);
    end
    check("rpost_ren_cnt", 32'(ren_cnt - r0), 32'd1);
    en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
